// File: rtl/alu_req_arbiter.sv
// Two-requester sequencer/arbiter in front of a shared 16-bit ALU with a tagged response channel.
// Optional build macro: ALU_ILLEGAL_TRAP_EN traps unimplemented opcodes with rsp_err instead of issuing them.
module alu_req_arbiter #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [3:0]       r0_opcode,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [3:0]       r1_opcode,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cf,
  output logic             rsp_sf,
  output logic             rsp_zf,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_cf,
  input  logic             alu_sf,
  input  logic             alu_zf
);

  localparam int unsigned CNT_W  = 4;
  localparam logic [3:0]  OP_SUB = 4'b0110;
  localparam logic [3:0]  OP_CMP = 4'b1011;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e             state_q, state_d;
  logic               last_id_q, last_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_cmp_q, is_cmp_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [3:0]         alu_opcode_q, alu_opcode_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_cf_q, rsp_cf_d;
  logic               rsp_sf_q, rsp_sf_d;
  logic               rsp_zf_q, rsp_zf_d;
  logic               rsp_err_q, rsp_err_d;

  logic               grant_valid_c;
  logic               grant_id_c;
  logic               accept_c;
  logic               trap_c;
  logic [3:0]         sel_opcode_c;
  logic [WIDTH-1:0]   sel_a_c;
  logic [WIDTH-1:0]   sel_b_c;

  // Round-robin grant: on a tie the requester that did not win last time goes first.
  always_comb begin
    grant_valid_c = 1'b0;
    grant_id_c    = 1'b0;
    if (r0_valid && r1_valid) begin
      grant_valid_c = 1'b1;
      grant_id_c    = ~last_id_q;
    end else if (r0_valid) begin
      grant_valid_c = 1'b1;
      grant_id_c    = 1'b0;
    end else if (r1_valid) begin
      grant_valid_c = 1'b1;
      grant_id_c    = 1'b1;
    end
  end

  assign r0_ready = !rst && (state_q == IDLE) && grant_valid_c && !grant_id_c;
  assign r1_ready = !rst && (state_q == IDLE) && grant_valid_c &&  grant_id_c;
  assign accept_c = (r0_valid && r0_ready) || (r1_valid && r1_ready);

  assign sel_opcode_c = grant_id_c ? r1_opcode : r0_opcode;
  assign sel_a_c      = grant_id_c ? r1_a      : r0_a;
  assign sel_b_c      = grant_id_c ? r1_b      : r0_b;

`ifdef ALU_ILLEGAL_TRAP_EN
  assign trap_c = (sel_opcode_c == 4'b0111) || (sel_opcode_c[3:2] == 2'b11);
`else
  assign trap_c = 1'b0;
`endif

  // Next-state and register updates.
  always_comb begin
    state_d      = state_q;
    last_id_d    = last_id_q;
    cnt_d        = cnt_q;
    is_cmp_d     = is_cmp_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_cf_d     = rsp_cf_q;
    rsp_sf_d     = rsp_sf_q;
    rsp_zf_d     = rsp_zf_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          last_id_d = grant_id_c;
          if (trap_c) begin
            // Trapped op bypasses the ALU entirely; its inputs keep their old values.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_id_c;
            rsp_data_d  = '0;
            rsp_cf_d    = 1'b0;
            rsp_sf_d    = 1'b0;
            rsp_zf_d    = 1'b0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d      = EXEC;
            cnt_d        = CNT_W'(SETTLE_CYCLES - 1);
            is_cmp_d     = (sel_opcode_c == OP_CMP);
            alu_a_d      = sel_a_c;
            alu_b_d      = sel_b_c;
            alu_opcode_d = (sel_opcode_c == OP_CMP) ? OP_SUB : sel_opcode_c;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_id_d    = last_id_q;
          rsp_data_d  = is_cmp_q ? '0 : alu_r;
          rsp_cf_d    = alu_cf;
          rsp_sf_d    = alu_sf;
          rsp_zf_d    = alu_zf;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_id_q    <= 1'b1;
      cnt_q        <= '0;
      is_cmp_q     <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_cf_q     <= 1'b0;
      rsp_sf_q     <= 1'b0;
      rsp_zf_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_id_q    <= last_id_d;
      cnt_q        <= cnt_d;
      is_cmp_q     <= is_cmp_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_cf_q     <= rsp_cf_d;
      rsp_sf_q     <= rsp_sf_d;
      rsp_zf_q     <= rsp_zf_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_cf     = rsp_cf_q;
  assign rsp_sf     = rsp_sf_q;
  assign rsp_zf     = rsp_zf_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: one DUT with SETTLE_CYCLES=1 and one with SETTLE_CYCLES=4.
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst, rst4;
  logic        r0_valid, r1_valid, rsp_ready;
  logic [3:0]  r0_opcode, r1_opcode;
  logic [15:0] r0_a, r0_b, r1_a, r1_b;

  logic        r0_ready, r1_ready, rsp_valid, rsp_id, rsp_cf, rsp_sf, rsp_zf, rsp_err;
  logic [15:0] rsp_data, alu_a, alu_b, alu_r;
  logic [3:0]  alu_opcode;
  logic        alu_cf, alu_sf, alu_zf;

  logic        r0_ready4, r1_ready4, rsp_valid4, rsp_id4, rsp_cf4, rsp_sf4, rsp_zf4, rsp_err4;
  logic [15:0] rsp_data4, alu_a4, alu_b4, alu_r4;
  logic [3:0]  alu_opcode4;
  logic        alu_cf4, alu_sf4, alu_zf4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Reference ALU: 0000 AND, 0001 OR, 0010 XOR, 0101 ADD, 0110 SUB (cf=borrow); others give R=0.
  function automatic logic [18:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    case (op)
      4'b0000: t = {1'b0, a & b};
      4'b0001: t = {1'b0, a | b};
      4'b0010: t = {1'b0, a ^ b};
      4'b0101: t = {1'b0, a} + {1'b0, b};
      4'b0110: t = {1'b0, a} - {1'b0, b};
      default: t = '0;
    endcase
    return {t[16], t[15], (t[15:0] == 16'h0), t[15:0]};
  endfunction

  assign {alu_cf, alu_sf, alu_zf, alu_r}     = alu_f(alu_opcode, alu_a, alu_b);
  assign {alu_cf4, alu_sf4, alu_zf4, alu_r4} = alu_f(alu_opcode4, alu_a4, alu_b4);

  alu_req_arbiter #(.WIDTH(16), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_cf(rsp_cf), .rsp_sf(rsp_sf), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_r(alu_r),
    .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf)
  );

  alu_req_arbiter #(.WIDTH(16), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4),
    .r0_valid(r0_valid), .r0_ready(r0_ready4), .r0_opcode(r0_opcode), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready4), .r1_opcode(r1_opcode), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_id(rsp_id4), .rsp_data(rsp_data4),
    .rsp_cf(rsp_cf4), .rsp_sf(rsp_sf4), .rsp_zf(rsp_zf4), .rsp_err(rsp_err4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_opcode(alu_opcode4), .alu_r(alu_r4),
    .alu_cf(alu_cf4), .alu_sf(alu_sf4), .alu_zf(alu_zf4)
  );

  task automatic test_reset();
    rst = 1'b1; rst4 = 1'b1; rsp_ready = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_opcode = 4'h0; r0_a = 16'h0; r0_b = 16'h0;
    r1_opcode = 4'h0; r1_a = 16'h0; r1_b = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", r0_ready, r1_ready); end
    checks++; if ({rsp_valid, rsp_id, rsp_cf, rsp_sf, rsp_zf, rsp_err} !== 6'b0) begin failures++; $display("FAIL reset_rsp_ctl got=%b exp=000000", {rsp_valid, rsp_id, rsp_cf, rsp_sf, rsp_zf, rsp_err}); end
    checks++; if (rsp_data !== 16'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
    checks++; if ({alu_a, alu_b, alu_opcode} !== 36'h0) begin failures++; $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_opcode); end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int got;
    logic exp_id;
    got = 0; exp_id = 1'b0;
    @(negedge clk);
    r0_valid = 1'b1; r0_opcode = 4'b0000; r0_a = 16'hFFFF; r0_b = 16'h00F0;
    r1_valid = 1'b1; r1_opcode = 4'b0101; r1_a = 16'h0001; r1_b = 16'h0001;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && got < 4; c++) begin
      #1;
      checks++; if (r0_ready && r1_ready) begin failures++; $display("FAIL rr_both_ready got=11 exp=not both"); end
      if (rsp_valid) begin
        checks++; if (rsp_id !== exp_id) begin failures++; $display("FAIL rr_id[%0d] got=%b exp=%b", got, rsp_id, exp_id); end
        checks++; if (rsp_data !== (exp_id ? 16'h0002 : 16'h00F0)) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", got, rsp_data, exp_id ? 16'h0002 : 16'h00F0); end
        exp_id = ~exp_id;
        got++;
        if (got == 4) begin r0_valid = 1'b0; r1_valid = 1'b0; end
      end
      @(negedge clk);
    end
    checks++; if (got != 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", got); end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    r0_valid = 1'b1; r0_opcode = 4'b0101; r0_a = 16'h0003; r0_b = 16'h0004; rsp_ready = 1'b1;
    #1;
    checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin failures++; $display("FAIL add_accept got=%b%b exp=10", r0_ready, r1_ready); end
    @(negedge clk);
    r0_valid = 1'b0;
    #1;
    checks++; if (r0_ready !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL add_exec got=rdy%b vld%b exp=rdy0 vld0", r0_ready, rsp_valid); end
    checks++; if (alu_opcode !== 4'b0101 || alu_a !== 16'h0003 || alu_b !== 16'h0004) begin failures++; $display("FAIL add_alu_in got=%h/%h/%h exp=5/0003/0004", alu_opcode, alu_a, alu_b); end
    @(negedge clk);
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_sf, rsp_zf, rsp_err} !== 5'b10000 || rsp_data !== 16'h0007) begin failures++; $display("FAIL add_rsp got=v%b id%b d%h sf%b zf%b e%b exp=v1 id0 d0007 sf0 zf0 e0", rsp_valid, rsp_id, rsp_data, rsp_sf, rsp_zf, rsp_err); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_rsp_drop got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_cmp(input logic [15:0] a, input logic [15:0] b, input logic exp_cf, input logic exp_sf, input logic exp_zf);
    @(negedge clk);
    r1_valid = 1'b1; r1_opcode = 4'b1011; r1_a = a; r1_b = b; rsp_ready = 1'b1;
    #1;
    checks++; if (r1_ready !== 1'b1) begin failures++; $display("FAIL cmp_accept got=%b exp=1", r1_ready); end
    @(negedge clk);
    r1_valid = 1'b0;
    #1;
    checks++; if (alu_opcode !== 4'b0110) begin failures++; $display("FAIL cmp_alu_op got=%b exp=0110", alu_opcode); end
    @(negedge clk);
    #1;
    checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b110 || rsp_data !== 16'h0000) begin failures++; $display("FAIL cmp_rsp got=v%b id%b e%b d%h exp=v1 id1 e0 d0000", rsp_valid, rsp_id, rsp_err, rsp_data); end
    checks++; if ({rsp_cf, rsp_sf, rsp_zf} !== {exp_cf, exp_sf, exp_zf}) begin failures++; $display("FAIL cmp_flags got=%b exp=%b", {rsp_cf, rsp_sf, rsp_zf}, {exp_cf, exp_sf, exp_zf}); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready = 1'b0;
    r0_valid = 1'b1; r0_opcode = 4'b0101; r0_a = 16'h8000; r0_b = 16'h8000;
    @(negedge clk);
    r0_valid = 1'b0;
    @(negedge clk);
    r0_valid = 1'b1; r0_opcode = 4'b0001; r0_a = 16'h1111; r0_b = 16'h2222;
    r1_valid = 1'b1; r1_opcode = 4'b0010; r1_a = 16'h00FF; r1_b = 16'h0F0F;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_cf, rsp_sf, rsp_zf} !== 5'b10101 || rsp_data !== 16'h0000) begin failures++; $display("FAIL bp_hold[%0d] got=v%b id%b cf%b sf%b zf%b d%h exp=v1 id0 cf1 sf0 zf1 d0000", c, rsp_valid, rsp_id, rsp_cf, rsp_sf, rsp_zf, rsp_data); end
      checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b%b exp=00", c, r0_ready, r1_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin failures++; $display("FAIL bp_hs_ready got=%b%b exp=00", r0_ready, r1_ready); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0 || r0_ready !== 1'b0 || r1_ready !== 1'b1) begin failures++; $display("FAIL bp_after got=v%b rdy%b%b exp=v0 rdy01", rsp_valid, r0_ready, r1_ready); end
    @(negedge clk);
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'h0FF0) begin failures++; $display("FAIL bp_next_rsp got=v%b id%b d%h exp=v1 id1 d0FF0", rsp_valid, rsp_id, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    r0_valid = 1'b1; r0_opcode = 4'b0111; r0_a = 16'h1234; r0_b = 16'h0001; rsp_ready = 1'b1;
    #1;
    checks++; if (r0_ready !== 1'b1) begin failures++; $display("FAIL ill_accept got=%b exp=1", r0_ready); end
    @(negedge clk);
    r0_valid = 1'b0;
    #1;
`ifdef ALU_ILLEGAL_TRAP_EN
    checks++; if ({rsp_valid, rsp_err, rsp_cf, rsp_sf, rsp_zf} !== 5'b11000 || rsp_data !== 16'h0) begin failures++; $display("FAIL ill_trap_rsp got=v%b e%b f%b%b%b d%h exp=v1 e1 f000 d0000", rsp_valid, rsp_err, rsp_cf, rsp_sf, rsp_zf, rsp_data); end
    checks++; if (alu_opcode !== 4'b0010 || alu_a !== 16'h00FF || alu_b !== 16'h0F0F) begin failures++; $display("FAIL ill_trap_alu got=%h/%h/%h exp=2/00FF/0F0F", alu_opcode, alu_a, alu_b); end
`else
    checks++; if (rsp_valid !== 1'b0 || alu_opcode !== 4'b0111) begin failures++; $display("FAIL ill_exec got=v%b op%b exp=v0 op0111", rsp_valid, alu_opcode); end
    @(negedge clk);
    #1;
    checks++; if ({rsp_valid, rsp_err, rsp_zf} !== 3'b101 || rsp_data !== 16'h0) begin failures++; $display("FAIL ill_rsp got=v%b e%b zf%b d%h exp=v1 e0 zf1 d0000", rsp_valid, rsp_err, rsp_zf, rsp_data); end
`endif
    @(negedge clk);
  endtask

  task automatic test_settle4();
    rst = 1'b1; rst4 = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    r0_valid = 1'b1; r0_opcode = 4'b0101; r0_a = 16'h0002; r0_b = 16'h0003;
    #1;
    checks++; if (r0_ready4 !== 1'b1) begin failures++; $display("FAIL s4_accept got=%b exp=1", r0_ready4); end
    @(negedge clk);
    r0_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (rsp_valid4 !== 1'b0 || alu_opcode4 !== 4'b0101) begin failures++; $display("FAIL s4_exec[%0d] got=v%b op%b exp=v0 op0101", c, rsp_valid4, alu_opcode4); end
      @(negedge clk);
    end
    #1;
    checks++; if (rsp_valid4 !== 1'b1 || rsp_data4 !== 16'h0005 || rsp_id4 !== 1'b0) begin failures++; $display("FAIL s4_rsp got=v%b d%h id%b exp=v1 d0005 id0", rsp_valid4, rsp_data4, rsp_id4); end
    @(negedge clk);
    r1_valid = 1'b1; r1_opcode = 4'b0110; r1_a = 16'h0009; r1_b = 16'h0002;
    #1;
    checks++; if (r1_ready4 !== 1'b1) begin failures++; $display("FAIL s4_rst_accept got=%b exp=1", r1_ready4); end
    @(negedge clk);
    r1_valid = 1'b0;
    #1;
    checks++; if (alu_opcode4 !== 4'b0110) begin failures++; $display("FAIL s4_rst_exec got=%b exp=0110", alu_opcode4); end
    rst4 = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid4 !== 1'b0 || {alu_a4, alu_b4, alu_opcode4} !== 36'h0) begin failures++; $display("FAIL s4_rst_state got=v%b alu=%h/%h/%h exp=v0 alu=0", rsp_valid4, alu_a4, alu_b4, alu_opcode4); end
    rst4 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      checks++; if (rsp_valid4 !== 1'b0) begin failures++; $display("FAIL s4_no_rsp[%0d] got=%b exp=0", c, rsp_valid4); end
    end
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    checks++; if (r0_ready4 !== 1'b1 || r1_ready4 !== 1'b0) begin failures++; $display("FAIL s4_tie got=%b%b exp=10", r0_ready4, r1_ready4); end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_add();
    test_cmp(16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1);
    test_cmp(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0);
    test_backpressure();
    test_illegal();
    test_settle4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
